// File: rtl/vector_packer.sv
// Stream-to-vector packer: gathers NUM_INPUTS elements (or fewer, ended by in_last) into one packed vector.
// Optional running element sum on sum_out when VECTOR_PACKER_SUM_EN is defined.
module vector_packer #(
   parameter int NUM_INPUTS  = 8,
   parameter int INPUT_WIDTH = 8,
   localparam int CNT_W      = $clog2(NUM_INPUTS + 1)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic [INPUT_WIDTH-1:0]            in_data,
   input  logic                              in_valid,
   input  logic                              in_last,
   output logic                              in_ready,
   output logic [NUM_INPUTS*INPUT_WIDTH-1:0] vec_out,
   output logic [CNT_W-1:0]                  vec_len,
   output logic                              vec_valid,
   input  logic                              vec_ready
`ifdef VECTOR_PACKER_SUM_EN
   ,
   output logic [INPUT_WIDTH-1:0]            sum_out
`endif
);

   // state | meaning
   // FILL  | accepting elements into slot cnt_q
   // HOLD  | vector presented, waiting for vec_ready
   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

   state_t                              state_q;
   logic [CNT_W-1:0]                    cnt_q;
   logic [NUM_INPUTS*INPUT_WIDTH-1:0]   vec_q;
   logic [CNT_W-1:0]                    len_q;
   logic                                accept;
   logic                                closing;

   assign in_ready  = (state_q == FILL) && !flush;
   assign accept    = in_ready && in_valid;
   assign closing   = in_last || (cnt_q == CNT_W'(NUM_INPUTS - 1));
   assign vec_out   = vec_q;
   assign vec_len   = len_q;
   assign vec_valid = (state_q == HOLD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         cnt_q   <= '0;
         vec_q   <= '0;
         len_q   <= '0;
      end else if (flush) begin
         state_q <= FILL;
         cnt_q   <= '0;
         vec_q   <= '0;
         len_q   <= '0;
      end else begin
         case (state_q)
            FILL: begin
               if (accept) begin
                  // slots double as the output register, so a short vector keeps zeros above cnt
                  for (int k = 0; k < NUM_INPUTS; k++) begin
                     if (cnt_q == CNT_W'(k))
                        vec_q[k*INPUT_WIDTH +: INPUT_WIDTH] <= in_data;
                  end
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (closing) begin
                     state_q <= HOLD;
                     len_q   <= cnt_q + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (vec_ready) begin
                  state_q <= FILL;
                  cnt_q   <= '0;
                  vec_q   <= '0;
                  len_q   <= '0;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

`ifdef VECTOR_PACKER_SUM_EN
   logic [INPUT_WIDTH-1:0] sum_q;

   assign sum_out = sum_q;

   // carry discarded to match the downstream adder's truncation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sum_q <= '0;
      else if (flush)
         sum_q <= '0;
      else if (accept)
         sum_q <= sum_q + in_data;
      else if (state_q == HOLD && vec_ready)
         sum_q <= '0;
   end
`endif

endmodule

// File: tb/tb_vector_packer.sv
// Self-checking bench for vector_packer (NUM_INPUTS=4, INPUT_WIDTH=8) against a queue-based reference model.
module tb_vector_packer;
   localparam int N = 4;
   localparam int W = 8;
   localparam int CW = $clog2(N + 1);

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic [W-1:0]    in_data = '0;
   logic            in_valid = 1'b0;
   logic            in_last = 1'b0;
   logic            in_ready;
   logic [N*W-1:0]  vec_out;
   logic [CW-1:0]   vec_len;
   logic            vec_valid;
   logic            vec_ready = 1'b0;
`ifdef VECTOR_PACKER_SUM_EN
   logic [W-1:0]    sum_out;
`endif

   vector_packer #(.NUM_INPUTS(N), .INPUT_WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .vec_out   (vec_out),
      .vec_len   (vec_len),
      .vec_valid (vec_valid),
      .vec_ready (vec_ready)
`ifdef VECTOR_PACKER_SUM_EN
      ,
      .sum_out   (sum_out)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: elements collected so far, and the vector currently on offer
   logic [W-1:0] pend_q[$];
   bit           holding = 1'b0;
   logic [N*W-1:0] exp_vec = '0;
   int           exp_len = 0;
   int           exp_sum = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic close_vector();
      exp_vec = '0;
      exp_sum = 0;
      foreach (pend_q[i]) begin
         exp_vec[i*W +: W] = pend_q[i];
         exp_sum += int'(pend_q[i]);
      end
      exp_sum = exp_sum % 256;
      exp_len = pend_q.size();
      pend_q.delete();
      holding = 1'b1;
   endtask

   // one cycle: drive at negedge, check in_ready, advance model at posedge, check outputs after it
   task automatic step(input bit v, input logic [W-1:0] d, input bit l, input bit r, input bit f);
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      vec_ready = r;
      flush     = f;
      #1;
      chk("in_ready", in_ready, !holding && !f);
      @(posedge clk);
      if (f) begin
         pend_q.delete();
         holding = 1'b0;
      end else if (!holding) begin
         if (v) begin
            pend_q.push_back(d);
            if (pend_q.size() == N || l) close_vector();
         end
      end else if (r) begin
         holding = 1'b0;
      end
      #1;
      chk("vec_valid", vec_valid, holding);
      if (holding) begin
         chk("vec_out", vec_out, exp_vec);
         chk("vec_len", vec_len, exp_len);
`ifdef VECTOR_PACKER_SUM_EN
         chk("sum_out", sum_out, exp_sum);
`endif
      end
      @(negedge clk);
   endtask

   task automatic idle(input bit r);
      step(1'b0, '0, 1'b0, r, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_vec_out"}, vec_out, 0);
      chk({tag, "_vec_len"}, vec_len, 0);
      chk({tag, "_vec_valid"}, vec_valid, 0);
`ifdef VECTOR_PACKER_SUM_EN
      chk({tag, "_sum_out"}, sum_out, 0);
`endif
   endtask

   initial begin
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);

      // full vector, consumer always ready
      step(1, 8'h11, 0, 1, 0);
      step(1, 8'h22, 0, 1, 0);
      step(1, 8'h33, 0, 1, 0);
      step(1, 8'h44, 0, 1, 0);
      chk("full_vec", vec_out, 32'h44332211);
      idle(1);
      idle(1);

      // short vector then full vector with no stale bits
      step(1, 8'hAA, 0, 0, 0);
      step(1, 8'hBB, 1, 0, 0);
      chk("short_vec", vec_out, 32'h0000BBAA);
      chk("short_len", vec_len, 2);
      idle(1);
      for (int i = 1; i <= 4; i++) step(1, W'(i), 0, 0, 0);
      chk("next_vec", vec_out, 32'h04030201);
      idle(1);

      // backpressure: extra elements during HOLD are ignored
      for (int i = 0; i < 4; i++) step(1, W'(8'h50 + i), 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 8'hEE, 1, 0, 0);
      idle(1);
      for (int i = 0; i < 4; i++) step(1, W'(8'h60 + i), 0, 1, 0);
      idle(1);

      // flush mid-fill with a concurrent element
      step(1, 8'h01, 0, 0, 0);
      step(1, 8'h02, 0, 0, 0);
      step(1, 8'hFF, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(1, W'(8'hA0 + i), 0, 0, 0);
      chk("post_flush_vec", vec_out, 32'hA3A2A1A0);
      // flush in HOLD wins over vec_ready
      step(0, 8'h00, 0, 1, 1);
      step(1, 8'h07, 1, 0, 0);
      chk("post_flush_short", vec_out, 32'h00000007);
      idle(1);

      // sum accumulation with wraparound
      step(1, 8'h10, 0, 0, 0);
      step(1, 8'h20, 0, 0, 0);
      step(1, 8'h30, 0, 0, 0);
      step(1, 8'hF0, 0, 0, 0);
      idle(1);
      step(1, 8'h05, 1, 0, 0);
      idle(1);

      // async reset mid-fill
      for (int i = 0; i < 3; i++) step(1, W'(8'hC0 + i), 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      pend_q.delete();
      holding = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(1, W'(8'hD0 + i), 0, 0, 0);
      chk("post_rst_vec", vec_out, 32'hD3D2D1D0);
      idle(1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 6) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vector_packer.md
# vector_packer

Stream-to-vector packer: accepts one INPUT_WIDTH-bit element per cycle over a valid/ready handshake and assembles NUM_INPUTS elements into one packed NUM_INPUTS*INPUT_WIDTH vector, presented over a second valid/ready handshake. It is the producer side of the packed-vector bus consumed by the vector adder. Upstream serial sources feed it, and the adder sums the packed vectors it delivers. It supports early termination (short vectors, zero-padded) and a synchronous flush.

## Interface
- NUM_INPUTS, 8, elements per vector (≥2)
- INPUT_WIDTH, 8, bits per element (≥1)
- CNT_W is derived as $clog2(NUM_INPUTS+1) and is not overridable.

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of partial or held vector
- in_data  in  INPUT_WIDTH  element
- in_valid  in  1  element valid
- in_last  in  1  element is final of a short vector (qualified by in_valid&&in_ready)
- in_ready  out  1  packer can accept an element
- vec_out  out  NUM_INPUTS*INPUT_WIDTH  packed vector; slot k = bits [k*INPUT_WIDTH +: INPUT_WIDTH]
- vec_len  out  CNT_W  number of filled slots (1..NUM_INPUTS)
- vec_valid  out  1  vector valid
- vec_ready  in  1  consumer accepts vector
- sum_out  out  INPUT_WIDTH  present only with VECTOR_PACKER_SUM_EN (see Configuration)

## Operation
- States: FILL, HOLD. Reset state is FILL.
- in_ready = (state==FILL) && !flush. vec_valid = (state==HOLD).
- FILL: each accepted element is written to slot cnt, and cnt increments. The first element of a vector goes to slot 0.
  - FILL→HOLD when the accepted element lands in slot NUM_INPUTS-1, or when in_last=1. vec_len = cnt+1 at that point.
- HOLD: vec_out, vec_len (and sum_out) are frozen. When vec_ready=1:
  - state goes to FILL,
  - cnt goes to 0,
  - all slots are cleared to 0, so unfilled slots of the next short vector read 0.
- in_last on slot NUM_INPUTS-1 is equivalent to a full vector. in_last is ignored when the element is not accepted.
- flush has priority over every other input:
  - In FILL: cnt=0, all slots cleared, and any concurrently presented element is not accepted.
  - In HOLD: the vector is discarded (vec_valid drops next cycle even if vec_ready=1 this cycle; the vector is not considered delivered), state goes to FILL, and slots are cleared.
- vec_ready is ignored in FILL. in_valid is ignored in HOLD.

## Timing
- Reset (rst_n low, async) sets:
  - state=FILL, cnt=0, vec_out=0, vec_len=0, vec_valid=0, sum_out=0.
  - in_ready=1 once rst_n is high (flush low).
  - Reset mid-fill or mid-hold discards all data.
- All outputs except in_ready are registered. in_ready is combinational from state and flush only, with no path from in_valid.
- Latency: vec_valid rises in the cycle after the final element handshake.
- Throughput: a full vector takes NUM_INPUTS fill cycles plus at least 1 HOLD cycle. There is no accept during HOLD, so the minimum period is NUM_INPUTS+1 cycles.
- vec_out, vec_len and vec_valid hold stable while vec_valid=1 && vec_ready=0.
- Back-to-back: in_ready is 1 in the cycle after the vec handshake.

## Configuration
- VECTOR_PACKER_SUM_EN defined:
  - Adds the sum_out port and a registered running sum of the accepted elements of the current vector, modulo 2^INPUT_WIDTH (carry discarded, matching the adder's truncation).
  - sum_out is valid with vec_valid.
  - sum_out is cleared with the slots on handshake, flush and reset.
- Not defined: no sum_out port and no accumulator logic. All other behaviour is identical.

## Test plan
NUM_INPUTS=4, INPUT_WIDTH=8 unless stated.
- Full vector: elements 0x11,0x22,0x33,0x44 with vec_ready=1 → vec_out=0x44332211, vec_len=4, vec_valid high exactly 1 cycle (the cycle after the 4th accept), then in_ready=1 the next cycle.
- Short vector: 0xAA, then 0xBB with in_last=1 → vec_out=0x0000BBAA, vec_len=2. The following full vector 1,2,3,4 → 0x04030201, with no stale bits.
- Backpressure: hold vec_ready=0 for 5 cycles after fill → vec_out stable, in_ready=0, extra in_valid ignored. Release → handshake, then the next vector is accepted normally.
- Flush:
  - After 2 accepts, assert flush with in_valid=1 → that element is not accepted, cnt resets. The next 4 elements form slots 0..3.
  - Flush in HOLD with vec_ready=1 → vec_valid drops, no delivery.
- Async reset mid-fill (after 3 accepts) → all outputs 0 immediately. After release, 4 new elements produce a clean vector.
- With VECTOR_PACKER_SUM_EN: elements 0x10,0x20,0x30,0xF0 → sum_out=0x50 (0x150 truncated). Short vector 0x05 with in_last → sum_out=0x05.
